fwd_scoreboard: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core, sitting beside the EX stage. It holds a registered shadow of the DEPTH pipeline stages younger than EX (EX/MEM, MEM/WB, …), each tagged with destination register, write-enable and load flag. It selects, per source operand of the instruction in EX, the nearest stage holding a valid producer. When that producer's data is not yet available, it raises a stall and inserts a bubble.

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_entry_pipe.sv | 25 ++
 rtl/fwd_scoreboard.sv | 92 +++++++++
 tb/tb_fwd_scoreboard.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared constants and entry record for the forwarding scoreboard
package fwd_pkg;

  // Default parameter values for the scoreboard and its entry pipe
  localparam int FWD_REG_BITS = 5;
  localparam int FWD_DEPTH    = 2;
  localparam int FWD_NUM_SRC  = 2;
  localparam int FWD_LOAD_LAT = 1;
  localparam int FWD_CNT_W    = 16;

  // Widest register index an entry can hold; narrower indices are zero-extended
  localparam int FWD_RD_MAX = 8;

  // Select code meaning "read the operand from the register file"
  localparam int FWD_RF = 0;

  // One shadowed pipeline stage: valid producer, destination, load flag
  typedef struct packed {
    logic                  v;
    logic [FWD_RD_MAX-1:0] rd;
    logic                  ld;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_entry_pipe.sv
// rtl/fwd_entry_pipe.sv - DEPTH-stage shadow of producers younger than EX
module fwd_entry_pipe
  import fwd_pkg::*;
#(
  parameter int DEPTH = FWD_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  fwd_entry_t             head,
  output fwd_entry_t [DEPTH:1]   stages
);

  // Age every record by one stage each cycle; the oldest simply drops off.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages[1] <= head;
      for (int k = 2; k <= DEPTH; k++) begin
        stages[k] <= stages[k-1];
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - operand forwarding select and load-use stall unit
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int REG_BITS = FWD_REG_BITS,
  parameter  int DEPTH    = FWD_DEPTH,
  parameter  int NUM_SRC  = FWD_NUM_SRC,
  parameter  int LOAD_LAT = FWD_LOAD_LAT,
  parameter  int CNT_W    = FWD_CNT_W,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ex_valid,
  input  logic                        ex_regwrite,
  input  logic                        ex_is_load,
  input  logic [REG_BITS-1:0]         ex_rd,
  input  logic [NUM_SRC*REG_BITS-1:0] ex_src,
  input  logic                        flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic [CNT_W-1:0]            stall_cnt
);

  // A load that never becomes forwardable inside the shadow cannot be resolved
  if (LOAD_LAT >= DEPTH) begin : g_bad_load_lat
    $error("fwd_scoreboard: LOAD_LAT must be smaller than DEPTH");
  end

  if (REG_BITS > FWD_RD_MAX) begin : g_bad_reg_bits
    $error("fwd_scoreboard: REG_BITS exceeds the entry destination width");
  end

  fwd_entry_t             head;
  fwd_entry_t [DEPTH:1]   stages;
  logic [NUM_SRC-1:0]     op_unready;
  logic                   raw_stall;

  // Record entering stage 1; a stalled or flushed EX slot becomes a bubble.
  always_comb begin
    head    = '0;
    head.v  = ex_valid & ex_regwrite & (ex_rd != '0) & ~stall & ~flush;
    head.rd = FWD_RD_MAX'(ex_rd);
    head.ld = ex_is_load;
  end

  fwd_entry_pipe #(
    .DEPTH (DEPTH)
  ) u_entry_pipe (
    .clk    (clk),
    .rst    (rst),
    .head   (head),
    .stages (stages)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_BITS-1:0] src;
    logic [SEL_W-1:0]    sel;
    logic                unready;

    assign src = ex_src[i*REG_BITS +: REG_BITS];

    // Scan oldest to youngest so the nearest matching stage is the one that sticks;
    // its readiness alone decides the stall, never an older ready copy.
    always_comb begin
      sel     = SEL_W'(FWD_RF);
      unready = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (stages[k].v && (stages[k].rd == FWD_RD_MAX'(src)) && (src != '0)) begin
          sel     = SEL_W'(k);
          unready = stages[k].ld && (k <= LOAD_LAT);
        end
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = ex_valid ? sel : SEL_W'(FWD_RF);
    assign op_unready[i]             = unready;
  end

  assign raw_stall = ex_valid & (|op_unready);
  assign stall     = raw_stall & ~flush;

  // Count stall cycles, pinning at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - randomized and directed bench for fwd_scoreboard
module tb_fwd_scoreboard;

  localparam int RB    = 5;
  localparam int D     = 2;
  localparam int NS    = 2;
  localparam int LL    = 1;
  localparam int CW    = 4;
  localparam int SW    = $clog2(D + 1);
  localparam int CMAX  = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  logic              ex_regwrite;
  logic              ex_is_load;
  logic [RB-1:0]     ex_rd;
  logic [NS*RB-1:0]  ex_src;
  logic              flush;
  logic [NS*SW-1:0]  fwd_sel;
  logic              stall;
  logic [CW-1:0]     stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(
    .REG_BITS (RB),
    .DEPTH    (D),
    .NUM_SRC  (NS),
    .LOAD_LAT (LL),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_regwrite (ex_regwrite),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_src      (ex_src),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  // Reference model: list of producers issued in recent cycles, youngest first
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } prod_t;

  prod_t hist[$];
  int    cnt_m;
  int    s_src[NS];
  int    e_sel[NS];
  bit    e_stall;
  bit    armed = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    prod_t p;
    p.v = 0; p.rd = 0; p.ld = 0;
    hist.delete();
    for (int k = 0; k < D; k++) hist.push_back(p);
    cnt_m = 0;
  endtask

  task automatic model_eval();
    bit raw;
    raw = 0;
    for (int i = 0; i < NS; i++) begin
      e_sel[i] = 0;
      if (ex_valid && s_src[i] != 0) begin
        for (int k = 0; k < D; k++) begin
          if (hist[k].v && hist[k].rd == s_src[i]) begin
            e_sel[i] = k + 1;
            if (hist[k].ld && (k + 1) <= LL) raw = 1;
            break;
          end
        end
      end
    end
    e_stall = raw && !flush;
  endtask

  // Advance the model at each clock edge using the inputs held across it
  always @(posedge clk) begin
    if (armed) begin
      if (!rst) begin
        model_clear();
      end else begin
        prod_t p;
        p.v  = ex_valid && ex_regwrite && (ex_rd != 0) && !e_stall && !flush;
        p.rd = int'(ex_rd);
        p.ld = ex_is_load;
        hist.push_front(p);
        void'(hist.pop_back());
        if (e_stall && cnt_m < CMAX) cnt_m++;
      end
    end
  end

  task automatic drive(input bit v, input bit rw, input bit ld, input int rd,
                       input int s0, input int s1, input bit fl, input bit r);
    @(negedge clk);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_is_load  = ld;
    ex_rd       = RB'(rd);
    s_src[0]    = s0;
    s_src[1]    = s1;
    ex_src      = {RB'(s1), RB'(s0)};
    flush       = fl;
    rst         = r;
    #1;
    model_eval();
    check("model_sel0", 32'(fwd_sel[SW-1:0]), e_sel[0]);
    check("model_sel1", 32'(fwd_sel[2*SW-1:SW]), e_sel[1]);
    check("model_stall", 32'(stall), 32'(e_stall));
    check("model_cnt", 32'(stall_cnt), cnt_m);
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 0; ex_regwrite = 0; ex_is_load = 0;
    ex_rd = '0; ex_src = '0; flush = 0;
    repeat (2) @(posedge clk);
    model_clear();
    armed = 1'b1;

    // Reset state: everything cleared, a would-be consumer sees the register file
    drive(1, 1, 0, 3, 3, 4, 0, 1);
    check("reset_sel", 32'(fwd_sel), 0);
    check("reset_stall", 32'(stall), 0);
    check("reset_cnt", 32'(stall_cnt), 0);

    // ALU back-to-back, then with one bubble between
    reset_pulse();
    drive(1, 1, 0, 3, 1, 2, 0, 1);
    drive(1, 1, 0, 4, 3, 0, 0, 1);
    check("alu_b2b_sel0", 32'(fwd_sel[SW-1:0]), 1);
    check("alu_b2b_stall", 32'(stall), 0);
    drive(1, 1, 0, 3, 1, 2, 0, 1);
    bubble();
    drive(1, 1, 0, 6, 3, 0, 0, 1);
    check("alu_gap_sel0", 32'(fwd_sel[SW-1:0]), 2);

    // Load-use: one stall, then forward from stage 2
    reset_pulse();
    drive(1, 1, 1, 5, 1, 2, 0, 1);
    drive(1, 1, 0, 6, 0, 5, 0, 1);
    check("lu_stall", 32'(stall), 1);
    drive(1, 1, 0, 6, 0, 5, 0, 1);
    check("lu_sel1", 32'(fwd_sel[2*SW-1:SW]), 2);
    check("lu_stall_after", 32'(stall), 0);
    check("lu_cnt", 32'(stall_cnt), 1);

    // Priority: nearest writer wins, and a nearer unready load forces a stall
    drive(1, 1, 0, 7, 0, 0, 0, 1);
    drive(1, 1, 0, 7, 0, 0, 0, 1);
    drive(1, 1, 0, 8, 7, 7, 0, 1);
    check("prio_sel0", 32'(fwd_sel[SW-1:0]), 1);
    check("prio_sel1", 32'(fwd_sel[2*SW-1:SW]), 1);
    drive(1, 1, 0, 7, 0, 0, 0, 1);
    drive(1, 1, 1, 7, 0, 0, 0, 1);
    drive(1, 1, 0, 8, 7, 7, 0, 1);
    check("prio_load_stall", 32'(stall), 1);

    // r0 destination and regwrite=0 never forward
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 4, 0, 0, 0, 1);
    drive(1, 1, 0, 9, 4, 0, 0, 1);
    check("r0_rw_sel", 32'(fwd_sel), 0);
    check("r0_rw_stall", 32'(stall), 0);

    // Flush beats stall; then a mid-stream reset
    reset_pulse();
    drive(1, 1, 1, 5, 0, 0, 0, 1);
    drive(1, 1, 0, 6, 5, 0, 1, 1);
    check("flush_stall", 32'(stall), 0);
    check("flush_cnt", 32'(stall_cnt), 0);
    drive(1, 1, 0, 10, 5, 6, 0, 1);
    check("flush_sel0", 32'(fwd_sel[SW-1:0]), 2);
    check("flush_sel1", 32'(fwd_sel[2*SW-1:SW]), 0);
    drive(1, 1, 1, 6, 0, 0, 0, 1);
    drive(1, 1, 0, 7, 6, 10, 0, 1);
    drive(1, 1, 0, 7, 6, 10, 0, 0);
    drive(1, 1, 0, 7, 6, 10, 0, 1);
    check("rst_mid_sel", 32'(fwd_sel), 0);
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_cnt", 32'(stall_cnt), 0);

    // Saturation: twenty load-use stalls on a 4-bit counter
    for (int n = 0; n < 20; n++) begin
      drive(1, 1, 1, 5, 0, 0, 0, 1);
      drive(1, 1, 0, 6, 5, 0, 0, 1);
    end
    bubble();
    check("sat_cnt", 32'(stall_cnt), CMAX);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
